param_chan_fifo: RTL and testbench

PARAM_CHAN_FIFO -- requirements
Module: param_chan_fifo

---
 rtl/param_chan_fifo_pkg.sv | 24 ++
 rtl/param_chan_fifo_ch.sv | 56 +++++
 rtl/param_chan_fifo.sv | 101 ++++++++++
 tb/tb_param_chan_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_chan_fifo_pkg.sv
// Shared types, legality limits and width helpers for the multi-channel FIFO.
// Imported by both the per-channel FIFO and the arbitrating top.
package param_chan_fifo_pkg;

   localparam int DEF_BITSA = 7;
   typedef logic [DEF_BITSA:0] payload_t;

   localparam int NCHAN_MIN = 2;
   localparam int NCHAN_MAX = 16;
   localparam int DEPTH_MIN = 2;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int chan_w(input int nchan);
      return (nchan > 1) ? $clog2(nchan) : 1;
   endfunction

endpackage

// File: rtl/param_chan_fifo_ch.sv
// Single-channel FIFO: power-of-two depth, natural pointer wrap, unreset storage.
// The caller guarantees no push when full and no pop when empty.
module param_chan_fifo_ch
   import param_chan_fifo_pkg::*;
#(
   parameter int  DEPTH  = 4,
   parameter type DATA_t = payload_t
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  DATA_t                   data_i,
   output DATA_t                   head_o,
   output logic [cnt_w(DEPTH)-1:0] fill_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   DATA_t         mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; fill gates whether the head is meaningful.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o = mem_q[rd_ptr_q];
   assign fill_o = cnt_q;

endmodule

// File: rtl/param_chan_fifo.sv
// NCHAN independent FIFOs merged onto one output by a round-robin arbiter
// whose grant is held while the downstream stalls.
module param_chan_fifo
   import param_chan_fifo_pkg::*;
#(
   parameter int  NCHAN  = 4,
   parameter int  DEPTH  = 4,
   parameter int  BITSA  = 7,
   parameter type DATA_t = logic [BITSA:0]
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NCHAN-1:0]        in_valid,
   output logic [NCHAN-1:0]        in_ready,
   input  DATA_t                   in_data [NCHAN],
   output logic                    out_valid,
   input  logic                    out_ready,
   output DATA_t                   out_data,
   output logic [chan_w(NCHAN)-1:0] out_chan,
   output logic [cnt_w(DEPTH)-1:0] fill [NCHAN]
);

   localparam int CHW = chan_w(NCHAN);
   localparam int CW  = cnt_w(DEPTH);

   logic             alive_q;
   logic             lock_q, lock_d;
   logic [CHW-1:0]   lock_chan_q, lock_chan_d;
   logic [CHW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CHW-1:0]   arb_chan;
   logic [NCHAN-1:0] nonempty;
   logic [NCHAN-1:0] push;
   logic [NCHAN-1:0] pop;
   logic             pop_fire;
   DATA_t            head [NCHAN];

   // alive_q keeps in_ready low until the first edge after reset release.
   for (genvar i = 0; i < NCHAN; i++) begin : g_ch
      assign nonempty[i] = (fill[i] != '0);
      assign in_ready[i] = alive_q && (fill[i] < CW'(DEPTH));
      assign push[i]     = in_valid[i] && in_ready[i];
      assign pop[i]      = pop_fire && (out_chan == CHW'(i));

      param_chan_fifo_ch #(
         .DEPTH  (DEPTH),
         .DATA_t (DATA_t)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .push_i (push[i]),
         .pop_i  (pop[i]),
         .data_i (in_data[i]),
         .head_o (head[i]),
         .fill_o (fill[i])
      );
   end

   // Scan downwards so the lowest offset from rr_ptr is the last to win.
   always_comb begin
      int             idx;
      logic [CHW-1:0] sel;
      idx      = 0;
      sel      = '0;
      arb_chan = rr_ptr_q;
      for (int k = NCHAN - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NCHAN) idx = idx - NCHAN;
         sel = CHW'(idx);
         if (nonempty[sel]) arb_chan = sel;
      end
   end

   assign out_valid = |nonempty;
   assign out_chan  = lock_q ? lock_chan_q : arb_chan;
   assign out_data  = head[out_chan];
   assign pop_fire  = out_valid && out_ready;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      lock_d      = out_valid && !out_ready;
      lock_chan_d = out_chan;
      if (pop_fire) begin
         rr_ptr_d = (out_chan == CHW'(NCHAN - 1)) ? '0 : out_chan + CHW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive_q     <= 1'b0;
         lock_q      <= 1'b0;
         lock_chan_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         alive_q     <= 1'b1;
         lock_q      <= lock_d;
         lock_chan_q <= lock_chan_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_param_chan_fifo.sv
// Directed bench for param_chan_fifo: an 8-bit 4x4 instance and a 2x2
// instance carrying a packed struct payload.
module tb_param_chan_fifo;

   typedef struct packed {
      logic [3:0] a;
      logic       b;
   } s_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [3:0] in_valid;
   logic [3:0] in_ready;
   logic [7:0] in_data [4];
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_chan;
   logic [2:0] fill [4];

   logic [1:0] s_in_valid;
   logic [1:0] s_in_ready;
   s_t         s_in_data [2];
   logic       s_out_valid;
   logic       s_out_ready;
   s_t         s_out_data;
   logic       s_out_chan;
   logic [1:0] s_fill [2];

   int total = 0;
   int bad   = 0;

   param_chan_fifo #(.NCHAN(4), .DEPTH(4), .BITSA(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .fill      (fill)
   );

   param_chan_fifo #(.NCHAN(2), .DEPTH(2), .DATA_t(s_t)) dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data),
      .out_chan  (s_out_chan),
      .fill      (s_fill)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = '0;
      out_ready   = 1'b0;
      s_in_valid  = '0;
      s_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) in_data[i] = '0;
      for (int i = 0; i < 2; i++) s_in_data[i] = '0;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_chan", 32'(out_chan), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_fill%0d", i), 32'(fill[i]), 0);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", 32'(in_ready), 32'hF);
      chk("rel_out_valid", 32'(out_valid), 0);

      // Two entries on every channel, then drain round-robin
      in_valid = 4'hF;
      for (int i = 0; i < 4; i++) in_data[i] = 8'hA0 + 8'(i);
      tick();
      for (int i = 0; i < 4; i++) in_data[i] = 8'hB0 + 8'(i);
      tick();
      in_valid = 4'h0;
      for (int i = 0; i < 4; i++) chk($sformatf("s2_fill%0d", i), 32'(fill[i]), 2);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("s2_chan%0d", k), 32'(out_chan), 32'(k % 4));
         chk($sformatf("s2_data%0d", k), 32'(out_data),
             32'((k < 4 ? 8'hA0 : 8'hB0) + 8'(k % 4)));
         tick();
      end
      chk("s2_drained", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Grant lock: channel 3 granted, channel 0 arrives with rr_ptr at 0
      in_valid    = 4'b1000;
      in_data[3]  = 8'h77;
      tick();
      chk("s4_valid", 32'(out_valid), 1);
      chk("s4_chan_a", 32'(out_chan), 3);
      in_valid   = 4'b0001;
      in_data[0] = 8'h55;
      tick();
      in_valid = 4'b0000;
      chk("s4_chan_b", 32'(out_chan), 3);
      chk("s4_data_b", 32'(out_data), 32'h77);
      tick();
      chk("s4_chan_c", 32'(out_chan), 3);
      chk("s4_data_c", 32'(out_data), 32'h77);
      out_ready = 1'b1;
      #1;
      chk("s4_chan_d", 32'(out_chan), 3);
      tick();
      chk("s4_chan_e", 32'(out_chan), 0);
      chk("s4_data_e", 32'(out_data), 32'h55);
      tick();
      chk("s4_drained", 32'(out_valid), 0);

      // Streaming on channel 2 with one-cycle latency
      in_valid   = 4'b0100;
      in_data[2] = 8'h11;
      chk("s1_pre_valid", 32'(out_valid), 0);
      tick();
      chk("s1_valid", 32'(out_valid), 1);
      chk("s1_chan", 32'(out_chan), 2);
      chk("s1_d11", 32'(out_data), 32'h11);
      in_data[2] = 8'h22;
      tick();
      chk("s1_d22", 32'(out_data), 32'h22);
      in_data[2] = 8'h33;
      tick();
      chk("s1_d33", 32'(out_data), 32'h33);
      chk("s1_fill", 32'(fill[2]), 1);
      in_valid = 4'b0000;
      tick();
      chk("s1_drained", 32'(out_valid), 0);

      // Fill channel 1 to capacity; a fifth push must be dropped
      out_ready = 1'b0;
      in_valid  = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         in_data[1] = 8'h41 + 8'(k);
         tick();
      end
      chk("s3_full_rdy", 32'(in_ready[1]), 0);
      chk("s3_full_fill", 32'(fill[1]), 4);
      in_data[1] = 8'h45;
      tick();
      in_valid = 4'b0000;
      chk("s3_over_fill", 32'(fill[1]), 4);
      chk("s3_head", 32'(out_data), 32'h41);
      out_ready = 1'b1;
      tick();
      chk("s3_pop_rdy", 32'(in_ready[1]), 1);
      chk("s3_pop_fill", 32'(fill[1]), 3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("s3_data%0d", k), 32'(out_data), 32'h42 + 32'(k));
         tick();
      end
      chk("s3_drained", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Reset while three entries are queued
      in_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         in_data[0] = 8'h60 + 8'(k);
         tick();
      end
      in_valid = 4'b0000;
      chk("s5_pre_fill", 32'(fill[0]), 3);
      rst_n = 1'b0;
      #1;
      chk("s5_out_valid", 32'(out_valid), 0);
      chk("s5_in_ready", 32'(in_ready), 0);
      chk("s5_out_chan", 32'(out_chan), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("s5_fill%0d", i), 32'(fill[i]), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("s5_rel_rdy", 32'(in_ready), 32'hF);
      chk("s5_rel_valid", 32'(out_valid), 0);
      out_ready  = 1'b1;
      in_valid   = 4'b0001;
      in_data[0] = 8'h99;
      tick();
      in_valid = 4'b0000;
      chk("s5_post_data", 32'(out_data), 32'h99);
      chk("s5_post_chan", 32'(out_chan), 0);
      tick();
      out_ready = 1'b0;

      // Packed struct payload passes through bit-exactly
      s_in_valid   = 2'b10;
      s_in_data[1] = '{a: 4'hA, b: 1'b1};
      tick();
      s_in_valid = 2'b00;
      chk("s6_valid", 32'(s_out_valid), 1);
      chk("s6_chan", 32'(s_out_chan), 1);
      chk("s6_data", 32'(s_out_data), 32'h15);
      s_out_ready  = 1'b1;
      s_in_valid   = 2'b01;
      s_in_data[0] = '{a: 4'h3, b: 1'b0};
      tick();
      s_in_valid = 2'b00;
      chk("s6_chan2", 32'(s_out_chan), 0);
      chk("s6_data2", 32'(s_out_data), 32'h06);
      tick();
      chk("s6_drained", 32'(s_out_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
